// File: rtl/floo_reg_responder.sv
// NoC target endpoint: decodes single-flit read/write requests against a small
// scratch register file and queues exactly one response flit per accepted request.
module floo_reg_responder #(
    parameter int unsigned NumRegs   = 8,
    parameter int unsigned AddrWidth = 48,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned IdWidth   = 6,
    parameter int unsigned XW        = 3,
    parameter int unsigned YW        = 3,
    parameter int unsigned RspDepth  = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [AddrWidth-1:0]   base_addr_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic                   req_write_i,
    input  logic [AddrWidth-1:0]   req_addr_i,
    input  logic [DataWidth-1:0]   req_wdata_i,
    input  logic [DataWidth/8-1:0] req_strb_i,
    input  logic [IdWidth-1:0]     req_id_i,
    input  logic [XW-1:0]          req_src_x_i,
    input  logic [YW-1:0]          req_src_y_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [DataWidth-1:0]   rsp_rdata_o,
    output logic                   rsp_err_o,
    output logic                   rsp_write_o,
    output logic [IdWidth-1:0]     rsp_id_o,
    output logic [XW-1:0]          rsp_dst_x_o,
    output logic [YW-1:0]          rsp_dst_y_o,
    output logic [31:0]            req_count_o
);

    localparam int unsigned StrbW = DataWidth / 8;
    localparam int unsigned IdxW  = $clog2(NumRegs);
    localparam int unsigned PtrW  = (RspDepth > 1) ? $clog2(RspDepth) : 1;
    localparam int unsigned CntW  = $clog2(RspDepth + 1);

    localparam logic [AddrWidth-1:0] RegBytes = AddrWidth'(NumRegs * 8);
    localparam logic [PtrW-1:0]      LastPtr  = PtrW'(RspDepth - 1);
    localparam logic [CntW-1:0]      FullCnt  = CntW'(RspDepth);

    typedef struct packed {
        logic [DataWidth-1:0] rdata;
        logic                 err;
        logic                 write;
        logic [IdWidth-1:0]   id;
        logic [XW-1:0]        dst_x;
        logic [YW-1:0]        dst_y;
    } rsp_t;

    logic [DataWidth-1:0] regs [NumRegs];
    rsp_t                 fifo_mem [RspDepth];
    logic [PtrW-1:0]      rd_ptr;
    logic [PtrW-1:0]      wr_ptr;
    logic [CntW-1:0]      fifo_count;

    logic [AddrWidth-1:0] off;
    logic                 hit;
    logic [IdxW-1:0]      idx;
    logic                 push;
    logic                 pop;
    rsp_t                 rsp_in;
    rsp_t                 rsp_head;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    // The lower-bound check also rejects addresses below base, where off wraps.
    always_comb begin
        off    = req_addr_i - base_addr_i;
        hit    = (req_addr_i >= base_addr_i) && (off < RegBytes) && (req_addr_i[2:0] == 3'b000);
        idx    = off[IdxW+2:3];
        rsp_in = '0;
        rsp_in.rdata = (hit && !req_write_i) ? regs[idx] : '0;
        rsp_in.err   = !hit;
        rsp_in.write = req_write_i;
        rsp_in.id    = req_id_i;
        rsp_in.dst_x = req_src_x_i;
        rsp_in.dst_y = req_src_y_i;
    end

    // A pop never makes room for a push in the same cycle.
    assign req_ready_o = !rst_i && (fifo_count < FullCnt);
    assign push        = req_valid_i && req_ready_o;
    assign pop         = rsp_valid_o && rsp_ready_i;

    assign rsp_head    = fifo_mem[rd_ptr];
    assign rsp_valid_o = (fifo_count != '0);
    assign rsp_rdata_o = rsp_head.rdata;
    assign rsp_err_o   = rsp_head.err;
    assign rsp_write_o = rsp_head.write;
    assign rsp_id_o    = rsp_head.id;
    assign rsp_dst_x_o = rsp_head.dst_x;
    assign rsp_dst_y_o = rsp_head.dst_y;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < NumRegs; r++) begin
                regs[r] <= '0;
            end
        end else if (push && hit && req_write_i) begin
            for (int b = 0; b < StrbW; b++) begin
                if (req_strb_i[b]) begin
                    regs[idx][b*8 +: 8] <= req_wdata_i[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= rsp_in;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + 1'b1;
            end else if (pop && !push) begin
                fifo_count <= fifo_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_count_o <= '0;
        end else if (push && (req_count_o != 32'hFFFF_FFFF)) begin
            req_count_o <= req_count_o + 32'd1;
        end
    end

endmodule
